key_debounce_multi: RTL and testbench
=====================================

# key_debounce_multi

Parametrised N-channel push-button debouncer, the successor to the single-key debounce/edge-detect block. Each channel synchronises one raw key, rejects bounce with a per-channel stability timer, and emits a debounced level plus one-cycle press, release, long-press and auto-repeat pulses. It sits between board key pins and the LED/control logic, with all keys in the CLOCK domain.

## Interface
- `N_KEYS`, 4: number of independent key channels (1–16).
- `ACTIVE_LOW`, 1: 1 = a key reads 0 when pressed; 0 = a key reads 1 when pressed.
- `T_DEBOUNCE`, 500_000: stable cycles required to accept a press or release (10 ms @ 50 MHz); ≥2.
- `T_LONG`, 50_000_000: cycles from the press pulse to the long-press pulse (1 s); must be > `T_DEBOUNCE`.
- `T_REPEAT`, 10_000_000: cycles between repeat pulses after long-press (200 ms); 0 disables repeat.
- `CLOCK`  in  1  system clock; single clock domain.
- `RESET`  in  1  asynchronous, active-low reset.
- `KEY`  in  N_KEYS  raw asynchronous key pins.
- `key_level`  out  N_KEYS  debounced state, 1 = pressed; reset 0.
- `key_press`  out  N_KEYS  one-cycle pulse on an accepted press; reset 0.
- `key_release`  out  N_KEYS  one-cycle pulse on an accepted release; reset 0.
- `key_long`  out  N_KEYS  one-cycle pulse `T_LONG` cycles after `key_press`, at most once per press; reset 0.
- `key_repeat`  out  N_KEYS  one-cycle pulse every `T_REPEAT` cycles after `key_long` while the key is held; reset 0.

## Operation
- Per channel: 2-FF synchroniser, then normalise so that p = 1 means pressed (invert if `ACTIVE_LOW`). On reset, the synchroniser FFs load the released level (all 1 when `ACTIVE_LOW`), so no event is generated out of reset.
- FSM per channel with one counter `cnt` of width `$clog2(max(T_DEBOUNCE,T_LONG,T_REPEAT)+1)`:
  - IDLE: level 0. p=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: p=0 → IDLE, cnt=0 (bounce rejected, no pulse). p=1 and cnt==T_DEBOUNCE → HELD, pulse key_press, level←1, cnt=0. Otherwise cnt++.
  - HELD: p=0 → RELEASE_WAIT, cnt=1. Otherwise cnt++; cnt==T_LONG-1 → pulse key_long, → REPEAT, cnt=0.
  - REPEAT: p=0 → RELEASE_WAIT, cnt=1. Otherwise, if T_REPEAT≠0: cnt==T_REPEAT-1 → pulse key_repeat, cnt=0, else cnt++.
  - RELEASE_WAIT: p=1 → back to HELD if key_long has not yet fired for this press, else to REPEAT; cnt=0 (glitch ignored, no pulse, long/repeat timers restart). p=0 and cnt==T_DEBOUNCE → IDLE, pulse key_release, level←0. Otherwise cnt++.
- At most one of press/release/long/repeat is high per channel per cycle. Channels are fully independent, so simultaneous events on different channels are all reported in the same cycle.
- Counters saturate and never wrap: every state exits before cnt overflows.
- RESET asserted mid-operation: all FSMs go to IDLE immediately and all outputs go to 0. No release pulse is emitted for a key that was held.

## Timing
- Clean press, first CLOCK edge sampling KEY pressed = edge 0: key_press and key_level rise after edge 2+T_DEBOUNCE (2 sync + T_DEBOUNCE stable samples).
- key_long fires T_LONG cycles after key_press; the first key_repeat fires T_REPEAT cycles after key_long.
- Clean release: key_release fires T_DEBOUNCE+2 cycles after the release sample; key_level falls in the same cycle.
- A bounce shorter than T_DEBOUNCE cycles produces no output change.
- All outputs are registered; there is no combinational path from KEY.

## Structure
- Package `key_pkg`: state enum (IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT), counter-width function, default timing constants for 50 MHz.
- Sub-module `key_debounce_chan`: one channel (synchroniser, FSM, counter). The top level instantiates N_KEYS copies in a generate loop.

## Test plan
Bench parameters: N_KEYS=4, T_DEBOUNCE=8, T_LONG=40, T_REPEAT=10, ACTIVE_LOW=1.
- Reset: hold RESET=0 with KEY=4'b0000 → all outputs 0; release reset with KEY=4'b1111 → no pulses for 100 cycles.
- Clean press of KEY[0] at edge 0, held for 100 cycles → key_press[0] at edge 10; key_long[0] at edge 50; key_repeat[0] at edges 60, 70, 80, 90, 100.
- Bounce: KEY[1] toggles with 3-cycle low/high periods for 30 cycles, then stays high → no pulses, key_level[1]=0 throughout.
- Release glitch: KEY[2] held, then a 4-cycle high glitch → no key_release; release held ≥10 cycles → exactly one key_release[2].
- Simultaneous: KEY[3:0] all pressed on the same edge → key_press=4'b1111 in a single cycle.
- Reset mid-hold: assert RESET while KEY[0] is in REPEAT → outputs 0 immediately; no key_release after reset deasserts with the key still pressed until it goes through PRESS_WAIT again.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the multi-key debouncer.
// No logic of its own; timing constants assume a 50 MHz CLOCK.
// Not applicable: no handshake, keys are sampled every cycle.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } key_state_t;

    localparam int DEF_T_DEBOUNCE = 500_000;
    localparam int DEF_T_LONG     = 50_000_000;
    localparam int DEF_T_REPEAT   = 10_000_000;

    // Counter must hold the largest terminal count of any state.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce/long/repeat FSM, shared counter.
// Latency: press/release pulses T_DEBOUNCE+2 cycles after the pin settles; outputs registered.
// No backpressure: pulses are single-cycle and must be consumed when presented.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int T_DEBOUNCE = DEF_T_DEBOUNCE,
    parameter int T_LONG     = DEF_T_LONG,
    parameter int T_REPEAT   = DEF_T_REPEAT
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic KEY,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int            CW        = cnt_width(T_DEBOUNCE, T_LONG, T_REPEAT);
    localparam logic          L_REL     = (ACTIVE_LOW != 0);
    localparam logic          REP_EN    = (T_REPEAT > 0);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_DEB     = CW'(T_DEBOUNCE);
    localparam logic [CW-1:0] C_LONG_M1 = CW'(T_LONG - 1);
    localparam logic [CW-1:0] C_REP_M1  = CW'((T_REPEAT > 0) ? T_REPEAT - 1 : 0);

    logic [1:0]    r_sync;
    logic          w_p;
    key_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_long_done, w_long_done_nxt;
    logic          r_level, w_level_nxt;
    logic          r_press, w_press_nxt;
    logic          r_release, w_release_nxt;
    logic          r_long, w_long_nxt;
    logic          r_repeat, w_repeat_nxt;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_sync <= {2{L_REL}};
        end else begin
            r_sync <= {r_sync[0], KEY};
        end
    end

    assign w_p       = r_sync[1] ^ L_REL;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_repeat    <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_repeat_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_p) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = C_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!w_p) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DEB) begin
                    w_state_nxt     = HELD;
                    w_cnt_nxt       = '0;
                    w_press_nxt     = 1'b1;
                    w_level_nxt     = 1'b1;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            HELD: begin
                if (!w_p) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = C_ONE;
                end else if (r_cnt == C_LONG_M1) begin
                    w_state_nxt     = REPEAT;
                    w_cnt_nxt       = '0;
                    w_long_nxt      = 1'b1;
                    w_long_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            REPEAT: begin
                if (!w_p) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = C_ONE;
                end else if (REP_EN) begin
                    if (r_cnt == C_REP_M1) begin
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                // A re-press glitch resumes the hold with fresh long/repeat timing.
                if (w_p) begin
                    w_state_nxt = r_long_done ? REPEAT : HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DEB) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;
    assign key_repeat  = r_repeat;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced key channels with press/release/long/repeat pulses.
// Latency: T_DEBOUNCE+2 cycles from a settled pin to press/release; all outputs registered.
// No backpressure: every channel reports its pulses in the cycle they occur.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int T_DEBOUNCE = DEF_T_DEBOUNCE,
    parameter int T_LONG     = DEF_T_LONG,
    parameter int T_REPEAT   = DEF_T_REPEAT
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .T_DEBOUNCE (T_DEBOUNCE),
            .T_LONG     (T_LONG),
            .T_REPEAT   (T_REPEAT)
        ) u_chan (
            .CLOCK       (CLOCK),
            .RESET       (RESET),
            .KEY         (KEY[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g]),
            .key_repeat  (key_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench: stimulus queues expected pulse events, a monitor pops and compares them.
module tb_key_debounce_multi;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int TL = 40;
    localparam int TR = 10;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [N-1:0] KEY;
    logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;

    key_debounce_multi #(
        .N_KEYS     (N),
        .ACTIVE_LOW (1),
        .T_DEBOUNCE (TD),
        .T_LONG     (TL),
        .T_REPEAT   (TR)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .KEY         (KEY),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic [3:0] rp;
    } ev_t;

    ev_t q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    // Insert in cycle order, merging events that land on the same cycle.
    task automatic push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] lg, input logic [3:0] rp);
        ev_t e;
        int  pos;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].c == c) begin
                e    = q[i];
                e.pr = e.pr | pr;
                e.rl = e.rl | rl;
                e.lg = e.lg | lg;
                e.rp = e.rp | rp;
                q[i] = e;
                return;
            end
            if (q[i].c > c) begin
                pos = i;
                break;
            end
        end
        e.c  = c;
        e.pr = pr;
        e.rl = rl;
        e.lg = lg;
        e.rp = rp;
        q.insert(pos, e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge CLOCK);
    endtask

    // Monitor: compare whenever the DUT pulses or an expected event falls due.
    initial begin : monitor
        ev_t         e;
        logic [15:0] act;
        logic [15:0] exp_v;
        logic        due;
        forever begin
            @(negedge CLOCK);
            act  = {key_press, key_release, key_long, key_repeat};
            due  = (q.size() > 0) && (q[0].c <= cyc);
            e.c  = cyc;
            e.pr = '0;
            e.rl = '0;
            e.lg = '0;
            e.rp = '0;
            if (due) e = q.pop_front();
            exp_v = {e.pr, e.rl, e.lg, e.rp};
            if (due || (act != '0)) begin
                vectors++;
                if (act !== exp_v) begin
                    miscompares++;
                    $display("FAIL pulses cyc=%0d got p/r/l/rp=%b_%b_%b_%b want %b_%b_%b_%b (due cyc %0d)",
                             cyc, act[15:12], act[11:8], act[7:4], act[3:0],
                             exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:0], e.c);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0;
        RESET = 1'b0;
        KEY   = 4'b0000;
        repeat (3) @(negedge CLOCK);
        chk("reset_outputs", 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);

        // Leave reset with all keys released: no activity expected.
        KEY   = 4'b1111;
        RESET = 1'b1;
        at(cyc + 100);
        chk("idle_level", 32'(key_level), 32'd0);

        // Clean press of key 0, held 100 cycles.
        e0     = cyc + 1;
        KEY[0] = 1'b0;
        push_ev(e0 + 10, 4'b0001, 4'b0, 4'b0, 4'b0);
        push_ev(e0 + 50, 4'b0, 4'b0, 4'b0001, 4'b0);
        for (int k = 1; k <= 5; k++) push_ev(e0 + 50 + 10 * k, 4'b0, 4'b0, 4'b0, 4'b0001);
        at(e0 + 9);
        chk("press0_before", 32'(key_level), 32'd0);
        at(e0 + 20);
        chk("press0_level", 32'(key_level), 32'(4'b0001));
        at(e0 + 100);
        KEY[0] = 1'b1;
        push_ev(e0 + 111, 4'b0, 4'b0001, 4'b0, 4'b0);
        at(e0 + 110);
        chk("rel0_level_hold", 32'(key_level), 32'(4'b0001));
        at(e0 + 111);
        chk("rel0_level_fall", 32'(key_level), 32'd0);
        at(e0 + 130);

        // Bounce on key 1: 3-cycle low/high periods never pass the filter.
        for (int i = 0; i < 10; i++) begin
            KEY[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                @(negedge CLOCK);
                chk("bounce1_level", 32'(key_level), 32'd0);
            end
        end
        KEY[1] = 1'b1;
        repeat (20) @(negedge CLOCK);
        chk("bounce1_after", 32'(key_level), 32'd0);

        // Key 2 with a 4-cycle release glitch; long timer restarts after it.
        e0     = cyc + 1;
        KEY[2] = 1'b0;
        push_ev(e0 + 10, 4'b0100, 4'b0, 4'b0, 4'b0);
        at(e0 + 20);
        KEY[2] = 1'b1;
        at(e0 + 24);
        KEY[2] = 1'b0;
        at(e0 + 30);
        chk("glitch2_level", 32'(key_level), 32'(4'b0100));
        push_ev(e0 + 67, 4'b0, 4'b0, 4'b0100, 4'b0);
        at(e0 + 70);
        KEY[2] = 1'b1;
        push_ev(e0 + 81, 4'b0, 4'b0100, 4'b0, 4'b0);
        at(e0 + 80);
        chk("rel2_level_hold", 32'(key_level), 32'(4'b0100));
        at(e0 + 81);
        chk("rel2_level_fall", 32'(key_level), 32'd0);
        at(e0 + 100);

        // All four keys pressed and released on the same edges.
        e0  = cyc + 1;
        KEY = 4'b0000;
        push_ev(e0 + 10, 4'b1111, 4'b0, 4'b0, 4'b0);
        at(e0 + 10);
        chk("all_level", 32'(key_level), 32'(4'b1111));
        at(e0 + 20);
        KEY = 4'b1111;
        push_ev(e0 + 31, 4'b0, 4'b1111, 4'b0, 4'b0);
        at(e0 + 45);
        chk("all_released", 32'(key_level), 32'd0);

        // Key 0: long press, glitch while repeating, then reset mid-hold.
        e0     = cyc + 1;
        KEY[0] = 1'b0;
        push_ev(e0 + 10, 4'b0001, 4'b0, 4'b0, 4'b0);
        push_ev(e0 + 50, 4'b0, 4'b0, 4'b0001, 4'b0);
        at(e0 + 52);
        KEY[0] = 1'b1;
        at(e0 + 54);
        KEY[0] = 1'b0;
        push_ev(e0 + 67, 4'b0, 4'b0, 4'b0, 4'b0001);
        at(e0 + 69);
        chk("rep0_level", 32'(key_level), 32'(4'b0001));
        at(e0 + 70);
        RESET = 1'b0;
        #1;
        chk("midreset_outputs", 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);
        at(e0 + 73);
        RESET = 1'b1;
        push_ev(e0 + 84, 4'b0001, 4'b0, 4'b0, 4'b0);
        at(e0 + 83);
        chk("repress0_before", 32'(key_level), 32'd0);
        at(e0 + 84);
        chk("repress0_level", 32'(key_level), 32'(4'b0001));
        at(e0 + 95);
        KEY[0] = 1'b1;
        push_ev(e0 + 106, 4'b0, 4'b0001, 4'b0, 4'b0);
        at(e0 + 130);
        chk("final_level", 32'(key_level), 32'd0);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
